// File: rtl/mem_stage.sv
// Memory-access stage: ALU results pass straight through, loads and stores run
// as req/ack bus transactions while upstream is stalled until completion.
module mem_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_wreg,
    input  logic [4:0]  i_wreg_addr,
    input  logic [31:0] i_wreg_data,
    input  logic [3:0]  i_mem_op,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_store_data,
    output logic        o_wreg,
    output logic [4:0]  o_wreg_addr,
    output logic [31:0] o_wreg_data,
    output logic        o_stall_req,
    output logic        o_except,
    output logic        o_bus_err,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [3:0]  o_bus_sel,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata
);
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       result_q, result_d;
    logic              isLoad_q, isLoad_d;
    logic              except_q, except_d;
    logic              err_q, err_d;
    logic [3:0]        memOp_q, memOp_d;
    logic [1:0]        byteOff_q, byteOff_d;
    logic              busReq_q, busReq_d;
    logic              busWe_q, busWe_d;
    logic [31:0]       busAddr_q, busAddr_d;
    logic [3:0]        busSel_q, busSel_d;
    logic [31:0]       busWdata_q, busWdata_d;

    logic        isByteOp, isHalfOp, isWordOp, isMemOp, isLoadOp, misaligned;
    logic [3:0]  selPattern;
    logic [31:0] wdataPattern;
    logic [7:0]  laneByte;
    logic [15:0] laneHalf;
    logic [31:0] loadValue;

    always_comb begin
        isByteOp     = (i_mem_op == 4'd1) || (i_mem_op == 4'd2) || (i_mem_op == 4'd6);
        isHalfOp     = (i_mem_op == 4'd3) || (i_mem_op == 4'd4) || (i_mem_op == 4'd7);
        isWordOp     = (i_mem_op == 4'd5) || (i_mem_op == 4'd8);
        isMemOp      = isByteOp || isHalfOp || isWordOp;
        isLoadOp     = (i_mem_op >= 4'd1) && (i_mem_op <= 4'd5);
        misaligned   = (isHalfOp && i_mem_addr[0]) ||
                       (isWordOp && (i_mem_addr[1:0] != 2'b00));
        selPattern   = 4'b1111;
        wdataPattern = i_store_data;
        if (isByteOp) begin
            selPattern   = 4'b0001 << i_mem_addr[1:0];
            wdataPattern = {4{i_store_data[7:0]}};
        end else if (isHalfOp) begin
            selPattern   = i_mem_addr[1] ? 4'b1100 : 4'b0011;
            wdataPattern = {2{i_store_data[15:0]}};
        end
    end

    // Lane selection uses the registered byte offset; rdata is only valid with ack.
    always_comb begin
        laneByte = i_bus_rdata[{byteOff_q, 3'b000} +: 8];
        laneHalf = byteOff_q[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
        case (memOp_q)
            4'd1:    loadValue = {{24{laneByte[7]}}, laneByte};
            4'd2:    loadValue = {24'd0, laneByte};
            4'd3:    loadValue = {{16{laneHalf[15]}}, laneHalf};
            4'd4:    loadValue = {16'd0, laneHalf};
            default: loadValue = i_bus_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            result_q   <= '0;
            isLoad_q   <= 1'b0;
            except_q   <= 1'b0;
            err_q      <= 1'b0;
            memOp_q    <= '0;
            byteOff_q  <= '0;
            busReq_q   <= 1'b0;
            busWe_q    <= 1'b0;
            busAddr_q  <= '0;
            busSel_q   <= '0;
            busWdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            isLoad_q   <= isLoad_d;
            except_q   <= except_d;
            err_q      <= err_d;
            memOp_q    <= memOp_d;
            byteOff_q  <= byteOff_d;
            busReq_q   <= busReq_d;
            busWe_q    <= busWe_d;
            busAddr_q  <= busAddr_d;
            busSel_q   <= busSel_d;
            busWdata_q <= busWdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        isLoad_d   = isLoad_q;
        except_d   = except_q;
        err_d      = err_q;
        memOp_d    = memOp_q;
        byteOff_d  = byteOff_q;
        busReq_d   = busReq_q;
        busWe_d    = busWe_q;
        busAddr_d  = busAddr_q;
        busSel_d   = busSel_q;
        busWdata_d = busWdata_q;
        case (state_q)
            IDLE: begin
                if (isMemOp) begin
                    isLoad_d = isLoadOp;
                    except_d = 1'b0;
                    err_d    = 1'b0;
                    if (misaligned) begin
                        except_d = 1'b1;
                        state_d  = DONE;
                    end else begin
                        busReq_d   = 1'b1;
                        busWe_d    = !isLoadOp;
                        busAddr_d  = {i_mem_addr[31:2], 2'b00};
                        busSel_d   = selPattern;
                        busWdata_d = wdataPattern;
                        memOp_d    = i_mem_op;
                        byteOff_d  = i_mem_addr[1:0];
                        cnt_d      = '0;
                        state_d    = BUS;
                    end
                end
            end
            BUS: begin
                if (i_bus_ack) begin
                    result_d = loadValue;
                    busReq_d = 1'b0;
                    state_d  = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    busReq_d = 1'b0;
                    err_d    = 1'b1;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                except_d = 1'b0;
                err_d    = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    // Every output is forced low while reset is held, including the pass-through path.
    always_comb begin
        o_wreg      = 1'b0;
        o_wreg_addr = '0;
        o_wreg_data = '0;
        o_stall_req = 1'b0;
        o_except    = 1'b0;
        o_bus_err   = 1'b0;
        o_bus_req   = 1'b0;
        o_bus_we    = 1'b0;
        o_bus_addr  = '0;
        o_bus_sel   = '0;
        o_bus_wdata = '0;
        if (!rst) begin
            o_bus_req   = busReq_q;
            o_bus_we    = busWe_q;
            o_bus_addr  = busAddr_q;
            o_bus_sel   = busSel_q;
            o_bus_wdata = busWdata_q;
            case (state_q)
                IDLE: begin
                    if (isMemOp) begin
                        o_stall_req = 1'b1;
                    end else begin
                        o_wreg      = i_wreg;
                        o_wreg_addr = i_wreg_addr;
                        o_wreg_data = i_wreg_data;
                    end
                end
                BUS: begin
                    o_stall_req = 1'b1;
                end
                default: begin
                    o_wreg      = i_wreg && isLoad_q && !err_q && !except_q;
                    o_wreg_addr = i_wreg_addr;
                    o_wreg_data = result_q;
                    o_except    = except_q;
                    o_bus_err   = err_q;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboarded bench for mem_stage: a driver issues ops and queues expectations,
// a bus responder answers requests, and a monitor checks each retiring op.
module tb_mem_stage;
    localparam int unsigned TMO = 4;

    logic        clk;
    logic        rst;
    logic        i_wreg;
    logic [4:0]  i_wreg_addr;
    logic [31:0] i_wreg_data;
    logic [3:0]  i_mem_op;
    logic [31:0] i_mem_addr;
    logic [31:0] i_store_data;
    logic        o_wreg;
    logic [4:0]  o_wreg_addr;
    logic [31:0] o_wreg_data;
    logic        o_stall_req;
    logic        o_except;
    logic        o_bus_err;
    logic        o_bus_req;
    logic        o_bus_we;
    logic [31:0] o_bus_addr;
    logic [3:0]  o_bus_sel;
    logic [31:0] o_bus_wdata;
    logic        i_bus_ack;
    logic [31:0] i_bus_rdata;

    typedef struct {
        logic        wreg;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        except;
        logic        err;
        int          stalls;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] rdata;
        bit          noAck;
    } bus_t;

    exp_t expQ[$];
    bus_t busQ[$];
    int   vectors = 0;
    int   errors  = 0;
    bit   forceAck = 0;

    mem_stage #(.TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_wreg      (i_wreg),
        .i_wreg_addr (i_wreg_addr),
        .i_wreg_data (i_wreg_data),
        .i_mem_op    (i_mem_op),
        .i_mem_addr  (i_mem_addr),
        .i_store_data(i_store_data),
        .o_wreg      (o_wreg),
        .o_wreg_addr (o_wreg_addr),
        .o_wreg_data (o_wreg_data),
        .o_stall_req (o_stall_req),
        .o_except    (o_except),
        .o_bus_err   (o_bus_err),
        .o_bus_req   (o_bus_req),
        .o_bus_we    (o_bus_we),
        .o_bus_addr  (o_bus_addr),
        .o_bus_sel   (o_bus_sel),
        .o_bus_wdata (o_bus_wdata),
        .i_bus_ack   (i_bus_ack),
        .i_bus_rdata (i_bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: expected retirement and bus transfer from the op's size and offset.
    task automatic applyStimulus(input logic [3:0] op, input logic wreg, input logic [4:0] waddr,
                                 input logic [31:0] wdata, input logic [31:0] addr,
                                 input logic [31:0] sdata, input int waits,
                                 input logic [31:0] rdata, input bit noAck);
        exp_t        e;
        bus_t        b;
        int          size;
        int          off;
        logic [31:0] mask;
        logic [31:0] raw;
        bit          retired;
        case (op)
            4'd1, 4'd2, 4'd6: size = 1;
            4'd3, 4'd4, 4'd7: size = 2;
            4'd5, 4'd8:       size = 4;
            default:          size = 0;
        endcase
        off = int'(addr % 4);
        e.wreg = wreg; e.waddr = waddr; e.wdata = wdata;
        e.except = 1'b0; e.err = 1'b0; e.stalls = 0;
        if (size != 0) begin
            e.wreg = 1'b0;
            if (addr % size != 0) begin
                e.except = 1'b1;
                e.stalls = 1;
            end else begin
                mask    = (size == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * size)) - 32'd1;
                b.we    = (op >= 4'd6);
                b.addr  = addr - 32'(off);
                b.sel   = 4'((32'd1 << size) - 32'd1) << off;
                b.wdata = (size == 1) ? (sdata & 32'hFF) * 32'h0101_0101 :
                          (size == 2) ? (sdata & 32'hFFFF) * 32'h0001_0001 : sdata;
                b.waits = waits; b.rdata = rdata; b.noAck = noAck;
                busQ.push_back(b);
                if (noAck) begin
                    e.err    = 1'b1;
                    e.stalls = 1 + TMO;
                end else begin
                    raw = (rdata >> (8 * off)) & mask;
                    if ((op == 4'd1 || op == 4'd3) && raw >= (mask + 32'd1) / 2)
                        raw = raw | ~mask;
                    e.wreg   = (op <= 4'd5) ? wreg : 1'b0;
                    e.wdata  = raw;
                    e.stalls = 2 + waits;
                end
            end
        end
        expQ.push_back(e);
        i_mem_op = op; i_wreg = wreg; i_wreg_addr = waddr; i_wreg_data = wdata;
        i_mem_addr = addr; i_store_data = sdata;
        retired = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!o_stall_req) begin
                retired = 1;
                break;
            end
        end
        if (!retired) begin
            vectors++;
            errors++;
            $display("[TB] FAIL retire_timeout: stall still %b after 200 cycles, expected 0", o_stall_req);
        end
        @(posedge clk);
        #1;
        i_mem_op = 4'd0; i_wreg = 1'b0;
    endtask

    // Bus responder: checks request fields every BUS cycle and acks after the chosen wait.
    initial begin
        bus_t cur;
        int   waitLeft;
        int   reqCycles;
        bit   active;
        active = 0; waitLeft = 0; reqCycles = 0;
        i_bus_ack = 1'b0; i_bus_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 0;
                i_bus_ack = 1'b0;
                continue;
            end
            if (o_bus_req) begin
                if (!active) begin
                    if (busQ.size() == 0) begin
                        vectors++;
                        errors++;
                        $display("[TB] FAIL unexpected_bus_req: req %b, expected 0", o_bus_req);
                        cur = '{we: o_bus_we, addr: o_bus_addr, sel: o_bus_sel, wdata: o_bus_wdata,
                                waits: 0, rdata: 32'd0, noAck: 1'b1};
                    end else begin
                        cur = busQ.pop_front();
                    end
                    active = 1; waitLeft = cur.waits; reqCycles = 0;
                end
                checkOutput("bus_we", o_bus_we, cur.we);
                checkOutput("bus_addr", o_bus_addr, cur.addr);
                checkOutput("bus_sel", o_bus_sel, cur.sel);
                checkOutput("bus_wdata", o_bus_wdata, cur.wdata);
                reqCycles++;
                if (!cur.noAck && waitLeft == 0) begin
                    i_bus_ack = 1'b1;
                    i_bus_rdata = cur.rdata;
                end else begin
                    if (waitLeft > 0) waitLeft--;
                    i_bus_ack = 1'b0;
                    i_bus_rdata = $urandom;
                end
            end else begin
                if (active && cur.noAck) checkOutput("timeout_req_cycles", reqCycles, TMO);
                active = 0;
                i_bus_ack = forceAck;
                i_bus_rdata = $urandom;
            end
        end
    end

    // Monitor: every non-stalled cycle with a pending expectation is a retirement.
    initial begin
        int   stallCnt;
        exp_t e;
        stallCnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stallCnt = 0;
                continue;
            end
            if (o_stall_req) begin
                stallCnt++;
            end else begin
                if (expQ.size() > 0) begin
                    e = expQ.pop_front();
                    checkOutput("wreg", o_wreg, e.wreg);
                    if (e.wreg) begin
                        checkOutput("wreg_addr", o_wreg_addr, e.waddr);
                        checkOutput("wreg_data", o_wreg_data, e.wdata);
                    end
                    checkOutput("except", o_except, e.except);
                    checkOutput("bus_err", o_bus_err, e.err);
                    checkOutput("stall_cycles", stallCnt, e.stalls);
                    checkOutput("req_at_retire", o_bus_req, 1'b0);
                end
                stallCnt = 0;
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0]  op;
        logic [31:0] addr;
        rst = 1'b1;
        i_wreg = 1'b1; i_wreg_addr = 5'd5; i_wreg_data = 32'h1234;
        i_mem_op = 4'd5; i_mem_addr = 32'h40; i_store_data = 32'h55;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_wreg", o_wreg, 1'b0);
        checkOutput("reset_wreg_addr", o_wreg_addr, 5'd0);
        checkOutput("reset_wreg_data", o_wreg_data, 32'd0);
        checkOutput("reset_stall", o_stall_req, 1'b0);
        checkOutput("reset_flags", {o_except, o_bus_err}, 2'b00);
        checkOutput("reset_bus_req", o_bus_req, 1'b0);
        checkOutput("reset_bus_we_sel", {o_bus_we, o_bus_sel}, 5'd0);
        checkOutput("reset_bus_addr", o_bus_addr, 32'd0);
        checkOutput("reset_bus_wdata", o_bus_wdata, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        i_mem_op = 4'd0;

        applyStimulus(4'd0, 1'b1, 5'd5, 32'h1234, 32'h0, 32'h0, 0, 32'h0, 0);
        applyStimulus(4'd1, 1'b1, 5'd7, 32'hDEAD, 32'h103, 32'h0, 2, 32'h80FF_0000, 0);
        applyStimulus(4'd7, 1'b1, 5'd3, 32'h0, 32'h202, 32'hABCD_5678, 0, 32'h0, 0);
        applyStimulus(4'd5, 1'b1, 5'd4, 32'h0, 32'h301, 32'h0, 0, 32'h0, 0);
        applyStimulus(4'd5, 1'b1, 5'd9, 32'h0, 32'h400, 32'h0, 0, 32'h0, 1);
        forceAck = 1;
        applyStimulus(4'd0, 1'b1, 5'd11, 32'hCAFE_F00D, 32'h0, 32'h0, 0, 32'h0, 0);
        applyStimulus(4'd2, 1'b1, 5'd12, 32'h0, 32'h411, 32'h0, 1, 32'h1234_9A00, 0);
        forceAck = 0;
        applyStimulus(4'd4, 1'b1, 5'd13, 32'h0, 32'h412, 32'h0, 3, 32'h8001_7FFF, 0);

        busQ.push_back('{we: 1'b0, addr: 32'h500, sel: 4'b1111, wdata: 32'h0,
                         waits: 0, rdata: 32'h0, noAck: 1'b1});
        i_mem_op = 4'd5; i_wreg = 1'b1; i_wreg_addr = 5'd14; i_mem_addr = 32'h500;
        i_store_data = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        i_mem_op = 4'd0;
        @(negedge clk);
        checkOutput("midbus_rst_req", o_bus_req, 1'b0);
        checkOutput("midbus_rst_stall", o_stall_req, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("after_rst_req", o_bus_req, 1'b0);
        checkOutput("after_rst_stall", o_stall_req, 1'b0);
        @(posedge clk);
        #1;
        applyStimulus(4'd5, 1'b1, 5'd15, 32'h0, 32'h600, 32'h0, 0, 32'h0000_0001, 0);

        for (int n = 0; n < 80; n++) begin
            op   = 4'($urandom_range(0, 15));
            addr = $urandom & 32'h0000_FFFF;
            applyStimulus(op, 1'($urandom), 5'($urandom), $urandom, addr, $urandom,
                          $urandom_range(0, 3), $urandom, ($urandom_range(0, 9) == 0));
        end

        checkOutput("expq_drained", expQ.size(), 0);
        checkOutput("busq_drained", busQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
